// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter (optional timeout: PS2_TX_TIMEOUT_EN)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_err
);

`ifdef PS2_TX_TIMEOUT_EN
  // One counter serves the inhibit window and then the frame timeout.
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
`else
  // Without the timeout the counter only spans the inhibit window; TIMEOUT_CYCLES has no effect.
  localparam int CNT_MAX = INHIBIT_CYCLES + 0 * TIMEOUT_CYCLES;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [8:0]    shreg, shreg_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic          clk_oe_n, data_oe_n, done_n, err_n;

  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic clk_fall;

  // Two-flop synchronizers for the open-collector lines, plus one stage of history for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign clk_fall = clk_prev & ~clk_sync;
  assign tx_ready = (state == IDLE);

  // State and all outputs are registered so the line drivers never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shreg       <= shreg_n;
      bit_cnt     <= bit_cnt_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      tx_done     <= done_n;
      tx_err      <= err_n;
    end
  end

  // Next-state and next-output logic; line changes follow detected falling edges only.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    err_n     = 1'b0;

    case (state)
      IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (tx_valid) begin
          shreg_n   = {~^tx_data, tx_data};
          cnt_n     = '0;
          bit_cnt_n = '0;
          clk_oe_n  = 1'b1;
          // A one-cycle inhibit window must already carry the start bit.
          data_oe_n = (INHIBIT_CYCLES == 1);
          state_n   = INHIBIT;
        end
      end
      INHIBIT: begin
        cnt_n = cnt + 1'b1;
        // Registered output: set one cycle early so data is low in the last inhibit cycle.
        if (cnt == CW'(INHIBIT_CYCLES - 2)) data_oe_n = 1'b1;
        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_n     = '0;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
          state_n   = START;
        end
      end
      START: begin
        if (clk_fall) begin
          data_oe_n = ~shreg[0];
          shreg_n   = shreg >> 1;
          bit_cnt_n = 4'd1;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (clk_fall) begin
          if (bit_cnt == 4'd9) begin
            data_oe_n = 1'b0;
            state_n   = ACK;
          end else begin
            data_oe_n = ~shreg[0];
            shreg_n   = shreg >> 1;
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          if (!data_sync) begin
            state_n = WAIT_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        state_n   = IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Frame watchdog from clock release until the device returns the bus to idle.
    if (state == START || state == SHIFT || state == ACK || state == WAIT_IDLE) begin
      cnt_n = cnt + 1'b1;
      if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        cnt_n     = '0;
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b1;
        state_n   = IDLE;
      end
    end
`endif
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter: INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz).
REQ-002 Parameter: TIMEOUT_CYCLES, 750000, max clk cycles from ps2_clk release to ack completion (15 ms at 50 MHz).
REQ-003 Port: clk  input  1  system clock; the block's only clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: tx_data  input  8  byte to send to the PS/2 device.
REQ-006 Port: tx_valid  input  1  request; byte accepted when tx_valid && tx_ready.
REQ-007 Port: tx_ready  output  1  high only in IDLE.
REQ-008 Port: ps2_clk_in  input  1  raw PS/2 clock line level (from top-level inout).
REQ-009 Port: ps2_data_in  input  1  raw PS/2 data line level.
REQ-010 Port: ps2_clk_oe  output  1  1 = drive ps2_clk low; 0 = release (high-Z).
REQ-011 Port: ps2_data_oe  output  1  1 = drive ps2_data low; 0 = release.
REQ-012 Port: tx_done  output  1  one-cycle pulse: byte sent and device acknowledged.
REQ-013 Port: tx_err  output  1  one-cycle pulse: no ack, or timeout.

Function
REQ-014 ps2_clk_in and ps2_data_in SHALL pass through 2-FF synchronizers; falling edge = synced previous 1, current 0.
REQ-015 States: IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE.
REQ-016 IDLE: on accept, latch tx_data and odd parity (~^tx_data) into a 9-bit shift register; next cycle INHIBIT with ps2_clk_oe=1.
REQ-017 INHIBIT: hold ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; assert ps2_data_oe=1 in the final cycle; then START.
REQ-018 START: ps2_clk_oe=0, ps2_data_oe=1 (start bit 0); timeout counter cleared and started; first ps2_clk falling edge -> SHIFT.
REQ-019 SHIFT: on falling edges 1..9, ps2_data_oe = ~bit (data LSB first, then parity); on falling edge 10, ps2_data_oe=0 (stop bit); then ACK.
REQ-020 ACK: on falling edge 11, sample synced data; 0 = ack -> WAIT_IDLE; 1 = tx_err pulse, -> IDLE.
REQ-021 WAIT_IDLE: when synced clk and data both 1, pulse tx_done, -> IDLE.
REQ-022 Line change SHALL occur in the cycle after the synchronized falling edge is detected; never on rising edges.
REQ-023 tx_valid outside IDLE SHALL be ignored; no queuing.
REQ-024 tx_done and tx_err SHALL never assert in the same cycle.
REQ-025 ps2_clk_oe and ps2_data_oe SHALL be registered outputs (glitch-free).

Reset
REQ-026 rst SHALL immediately force IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, counters=0, shift register=0; tx_ready=1 in the first cycle after release.
REQ-027 Reset mid-frame SHALL abandon the frame without tx_done or tx_err.

Configuration
REQ-028 Macro PS2_TX_TIMEOUT_EN defined: from START through WAIT_IDLE, counter reaching TIMEOUT_CYCLES SHALL release both lines, pulse tx_err, -> IDLE.
REQ-029 Macro PS2_TX_TIMEOUT_EN undefined: no timeout counter synthesized; block waits indefinitely for device clocks; tx_err only from missing ack.

Verification
REQ-030 Send 0xED; device model clocks 11 edges with ack -> data bits 1,0,1,1,0,1,1,1 then parity 1, stop released, one tx_done pulse.
REQ-031 Send 0xF4 -> parity 0; ps2_clk_oe high for exactly 5000 cycles before release; tx_ready low until tx_done.
REQ-032 Device holds data high at edge 11 -> one tx_err pulse, no tx_done, both oe 0, back to IDLE.
REQ-033 PS2_TX_TIMEOUT_EN defined, device never clocks -> tx_err exactly 750000 cycles after ps2_clk release; lines released.
REQ-034 rst asserted after edge 5 of 0xED -> both oe 0 same cycle, no done/err pulse; next 0xF4 sends correctly.
REQ-035 tx_valid held high through a frame -> exactly one byte sent; second accepted only after tx_done.
